// File: rtl/serial_bus_slave_port.sv
// rtl/serial_bus_slave_port.sv - serial-bus slave front end: control-frame decode, serial write collection, serial read-back
module serial_bus_slave_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 2,
    parameter int SLAVE_ID   = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  control,
    input  logic                  wD,
    input  logic                  valid,
    output logic                  rD,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int FRAME_BITS = ID_WIDTH + 2 + ADDR_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS > DATA_WIDTH ? FRAME_BITS : DATA_WIDTH);

    localparam logic [CNT_W-1:0]    CTRL_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] MY_ID     = ID_WIDTH'(SLAVE_ID);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_WRITE,
        S_RD_FETCH,
        S_RD_LOAD,
        S_RD_SHIFT
    } state_t;

    state_t                  state;
    logic [1:0]              start_sr;
    logic [FRAME_BITS-2:0]   frame_sr;
    logic [DATA_WIDTH-2:0]   shift_sr;
    logic [CNT_W-1:0]        cnt;
    logic                    burst;
    logic                    words_done;

    logic [FRAME_BITS-1:0]   frame_word;
    logic [ID_WIDTH-1:0]     frame_id;
    logic                    frame_rw;
    logic                    frame_b;
    logic [ADDR_WIDTH-1:0]   frame_addr;
    logic [DATA_WIDTH-1:0]   wr_word;

    // The bit being sampled this cycle completes the frame/word, so decode from the shifted view
    assign frame_word = {frame_sr, control};
    assign frame_id   = frame_word[FRAME_BITS-1 -: ID_WIDTH];
    assign frame_rw   = frame_word[ADDR_WIDTH+1];
    assign frame_b    = frame_word[ADDR_WIDTH];
    assign frame_addr = frame_word[ADDR_WIDTH-1:0];
    assign wr_word    = {shift_sr, wD};
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            start_sr   <= '0;
            frame_sr   <= '0;
            shift_sr   <= '0;
            cnt        <= '0;
            burst      <= 1'b0;
            words_done <= 1'b0;
            rD         <= 1'b0;
            ready      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ({start_sr, control} == 3'b111) begin
                        state    <= S_CTRL;
                        start_sr <= '0;
                        cnt      <= '0;
                    end else begin
                        start_sr <= {start_sr[0], control};
                    end
                end
                S_CTRL: begin
                    frame_sr <= frame_word[FRAME_BITS-2:0];
                    if (cnt == CTRL_LAST) begin
                        cnt <= '0;
                        if (frame_id != MY_ID) begin
                            state <= S_IDLE;
                        end else begin
                            burst      <= frame_b;
                            mem_addr   <= frame_addr;
                            words_done <= 1'b0;
                            state      <= frame_rw ? S_WRITE : S_RD_FETCH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WRITE: begin
                    // Address advances only after its strobe cycle so the strobe sees the old address
                    if (mem_we && burst)
                        mem_addr <= mem_addr + ADDR_ONE;
                    if (valid) begin
                        shift_sr <= wr_word[DATA_WIDTH-2:0];
                        if (cnt == DATA_LAST) begin
                            cnt        <= '0;
                            mem_we     <= 1'b1;
                            mem_wdata  <= wr_word;
                            words_done <= 1'b1;
                            if (!burst)
                                state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else if (cnt != '0) begin
                        state <= S_IDLE;
                    end else if (burst && words_done) begin
                        state <= S_IDLE;
                    end
                end
                S_RD_FETCH: begin
                    state <= S_RD_LOAD;
                end
                S_RD_LOAD: begin
                    rD       <= mem_rdata[DATA_WIDTH-1];
                    shift_sr <= mem_rdata[DATA_WIDTH-2:0];
                    ready    <= 1'b1;
                    cnt      <= '0;
                    state    <= S_RD_SHIFT;
                end
                S_RD_SHIFT: begin
                    if (cnt == DATA_LAST) begin
                        ready <= 1'b0;
                        rD    <= 1'b0;
                        cnt   <= '0;
                        if (burst && valid) begin
                            mem_addr <= mem_addr + ADDR_ONE;
                            state    <= S_RD_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        rD       <= shift_sr[DATA_WIDTH-2];
                        shift_sr <= shift_sr << 1;
                        cnt      <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
